// File: rtl/heap_sift_node.sv
// rtl/heap_sift_node.sv - sift-down stage for one level of a pipelined hardware heap
//
// Purpose:
//   Accepts a sift request (value v, slot index p) from the level above. It reads
//   both children of slot p from the next level's store and compares them with v.
//   The winner is written into this level's slot. When a child wins, the displaced
//   v is forwarded to the next level's node.
//
// Configuration macro:
//   HEAP_MAX_ORDER_EN - defined: max-heap (larger child, request wins on v >= m,
//                       empty slots all-zeros); undefined: min-heap (smaller
//                       child, request wins on v <= m, empty slots all-ones).
//
// Parameters:
//   DATA_WIDTH - key width
//   ADDR_WIDTH - address width shared with data_store
//   IS_LEAF    - 1: no child level, the request always wins and is never forwarded
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/ready     request handshake from the level above
//   req_idx, req_data   slot index p and value v
//   ch_addr             child-store read address (lm_addr/rm_addr), equals p
//   ch_l_dout/ch_r_dout child-store read data (left/right)
//   par_addr/branch     own-store bottom-node address p>>1 and branch p[0]
//   par_we, par_din     own-store write pulse and data
//   fwd_valid/ready     request handshake to the next level
//   fwd_idx, fwd_data   forwarded slot index {p,b} and displaced value
module heap_sift_node #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int IS_LEAF    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_idx,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic [ADDR_WIDTH-1:0] ch_addr,
  input  logic [DATA_WIDTH-1:0] ch_l_dout,
  input  logic [DATA_WIDTH-1:0] ch_r_dout,
  output logic [ADDR_WIDTH-1:0] par_addr,
  output logic                  par_branch,
  output logic                  par_we,
  output logic [DATA_WIDTH-1:0] par_din,
  output logic                  fwd_valid,
  input  logic                  fwd_ready,
  output logic [ADDR_WIDTH-1:0] fwd_idx,
  output logic [DATA_WIDTH-1:0] fwd_data
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CMP  = 3'd2,
    S_WR   = 3'd3,
    S_FWD  = 3'd4,
    S_HOLD = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] p_q, p_d;
  logic [DATA_WIDTH-1:0] v_q, v_d;
  logic                  hold_q, hold_d;

  logic                  req_ready_d;
  logic [ADDR_WIDTH-1:0] ch_addr_d;
  logic [ADDR_WIDTH-1:0] par_addr_d;
  logic                  par_branch_d;
  logic                  par_we_d;
  logic [DATA_WIDTH-1:0] par_din_d;
  logic                  fwd_valid_d;
  logic [ADDR_WIDTH-1:0] fwd_idx_d;
  logic [DATA_WIDTH-1:0] fwd_data_d;

  // Child selection: b is the branch of the winning child m; left wins ties.
  logic                  sel_right;
  logic [DATA_WIDTH-1:0] m_val;
  logic                  req_wins;
  logic [ADDR_WIDTH:0]   fwd_idx_full;

  always_comb begin
`ifdef HEAP_MAX_ORDER_EN
    sel_right = (ch_r_dout > ch_l_dout);
    m_val     = sel_right ? ch_r_dout : ch_l_dout;
    req_wins  = (v_q >= m_val);
`else
    sel_right = (ch_r_dout < ch_l_dout);
    m_val     = sel_right ? ch_r_dout : ch_l_dout;
    req_wins  = (v_q <= m_val);
`endif
    // {p,b} may overflow by one bit; the top level never sizes the heap past it.
    fwd_idx_full = {p_q, sel_right};
  end

  always_comb begin
    state_d      = state_q;
    p_d          = p_q;
    v_d          = v_q;
    hold_d       = hold_q;
    req_ready_d  = req_ready;
    ch_addr_d    = ch_addr;
    par_addr_d   = par_addr;
    par_branch_d = par_branch;
    par_we_d     = 1'b0;
    par_din_d    = par_din;
    fwd_valid_d  = fwd_valid;
    fwd_idx_d    = fwd_idx;
    fwd_data_d   = fwd_data;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          p_d          = req_idx;
          v_d          = req_data;
          req_ready_d  = 1'b0;
          par_addr_d   = req_idx >> 1;
          par_branch_d = req_idx[0];
          if (IS_LEAF != 0) begin
            // No children to read: the request wins outright.
            state_d   = S_WR;
            par_we_d  = 1'b1;
            par_din_d = req_data;
          end else begin
            state_d   = S_RD;
            ch_addr_d = req_idx;
          end
        end
      end
      S_RD: begin
        state_d = S_CMP;
      end
      S_CMP: begin
        state_d  = S_WR;
        par_we_d = 1'b1;
        if (req_wins) begin
          par_din_d = v_q;
        end else begin
          par_din_d   = m_val;
          fwd_valid_d = 1'b1;
          fwd_idx_d   = fwd_idx_full[ADDR_WIDTH-1:0];
          fwd_data_d  = v_q;
        end
      end
      S_WR: begin
        if (fwd_valid) begin
          if (fwd_ready) begin
            fwd_valid_d = 1'b0;
            hold_d      = 1'b0;
            state_d     = S_HOLD;
          end else begin
            state_d = S_FWD;
          end
        end else begin
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_FWD: begin
        if (fwd_ready) begin
          fwd_valid_d = 1'b0;
          hold_d      = 1'b0;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        // Two cycles so the child's write lands before our next RD sample.
        if (hold_q) begin
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          hold_d = 1'b1;
        end
      end
      default: begin
        req_ready_d = 1'b1;
        fwd_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      p_q        <= '0;
      v_q        <= '0;
      hold_q     <= 1'b0;
      req_ready  <= 1'b1;
      ch_addr    <= '0;
      par_addr   <= '0;
      par_branch <= 1'b0;
      par_we     <= 1'b0;
      par_din    <= '0;
      fwd_valid  <= 1'b0;
      fwd_idx    <= '0;
      fwd_data   <= '0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      v_q        <= v_d;
      hold_q     <= hold_d;
      req_ready  <= req_ready_d;
      ch_addr    <= ch_addr_d;
      par_addr   <= par_addr_d;
      par_branch <= par_branch_d;
      par_we     <= par_we_d;
      par_din    <= par_din_d;
      fwd_valid  <= fwd_valid_d;
      fwd_idx    <= fwd_idx_d;
      fwd_data   <= fwd_data_d;
    end
  end

endmodule

// File: tb/tb_heap_sift_node.sv
// tb/tb_heap_sift_node.sv - self-checking bench for heap_sift_node
module tb_heap_sift_node;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_idx = '0;
  logic [DW-1:0] req_data = '0;
  logic [AW-1:0] ch_addr;
  logic [DW-1:0] ch_l_dout = '0;
  logic [DW-1:0] ch_r_dout = '0;
  logic [AW-1:0] par_addr;
  logic          par_branch;
  logic          par_we;
  logic [DW-1:0] par_din;
  logic          fwd_valid;
  logic          fwd_ready = 1'b1;
  logic [AW-1:0] fwd_idx;
  logic [DW-1:0] fwd_data;

  logic          l_req_valid = 1'b0;
  logic          l_req_ready;
  logic [AW-1:0] l_req_idx = '0;
  logic [DW-1:0] l_req_data = '0;
  logic [AW-1:0] l_ch_addr;
  logic [DW-1:0] l_ch_l_dout = '0;
  logic [DW-1:0] l_ch_r_dout = '0;
  logic [AW-1:0] l_par_addr;
  logic          l_par_branch;
  logic          l_par_we;
  logic [DW-1:0] l_par_din;
  logic          l_fwd_valid;
  logic          l_fwd_ready = 1'b1;
  logic [AW-1:0] l_fwd_idx;
  logic [DW-1:0] l_fwd_data;

  always #5 clk = ~clk;

  heap_sift_node #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IS_LEAF(0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx), .req_data(req_data),
    .ch_addr(ch_addr), .ch_l_dout(ch_l_dout), .ch_r_dout(ch_r_dout),
    .par_addr(par_addr), .par_branch(par_branch), .par_we(par_we), .par_din(par_din),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_idx(fwd_idx), .fwd_data(fwd_data)
  );

  heap_sift_node #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IS_LEAF(1)) leaf (
    .clk(clk), .rst(rst),
    .req_valid(l_req_valid), .req_ready(l_req_ready), .req_idx(l_req_idx), .req_data(l_req_data),
    .ch_addr(l_ch_addr), .ch_l_dout(l_ch_l_dout), .ch_r_dout(l_ch_r_dout),
    .par_addr(l_par_addr), .par_branch(l_par_branch), .par_we(l_par_we), .par_din(l_par_din),
    .fwd_valid(l_fwd_valid), .fwd_ready(l_fwd_ready), .fwd_idx(l_fwd_idx), .fwd_data(l_fwd_data)
  );

  typedef struct {
    logic [AW-1:0] p;
    logic [DW-1:0] v;
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic [DW-1:0] exp_din;
    logic          exp_fwd;
    logic [AW-1:0] exp_fidx;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [AW-1:0] p, input logic [DW-1:0] v, input logic [DW-1:0] l,
                     input logic [DW-1:0] r, input logic [DW-1:0] din, input logic f,
                     input logic [AW-1:0] fidx);
    vec_t t;
    t.p = p; t.v = v; t.l = l; t.r = r; t.exp_din = din; t.exp_fwd = f; t.exp_fidx = fidx;
    vecs.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request; leaves the node at edge k+2 (WR cycle) after checking WR outputs.
  task automatic start_req(input vec_t t, input string tag);
    check({tag, " ready_before"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_idx = t.p; req_data = t.v;
    ch_l_dout = t.l; ch_r_dout = t.r;
    tick();                                    // edge k
    req_valid = 1'b0;
    check({tag, " ch_addr"}, 64'(ch_addr), 64'(t.p));
    check({tag, " ready_low_rd"}, 64'(req_ready), 64'd0);
    check({tag, " we_rd"}, 64'(par_we), 64'd0);
    tick();                                    // edge k+1
    check({tag, " we_cmp"}, 64'(par_we), 64'd0);
    tick();                                    // edge k+2
    check({tag, " we_wr"}, 64'(par_we), 64'd1);
    check({tag, " par_addr"}, 64'(par_addr), 64'(t.p >> 1));
    check({tag, " par_branch"}, 64'(par_branch), 64'(t.p[0]));
    check({tag, " par_din"}, 64'(par_din), 64'(t.exp_din));
    check({tag, " fwd_valid"}, 64'(fwd_valid), 64'(t.exp_fwd));
    if (t.exp_fwd) begin
      check({tag, " fwd_idx"}, 64'(fwd_idx), 64'(t.exp_fidx));
      check({tag, " fwd_data"}, 64'(fwd_data), 64'(t.v));
    end
  endtask

  task automatic run_vec(input vec_t t, input string tag);
    fwd_ready = 1'b1;
    start_req(t, tag);
    tick();                                    // edge k+3
    check({tag, " we_after"}, 64'(par_we), 64'd0);
    check({tag, " fwd_after"}, 64'(fwd_valid), 64'd0);
    if (!t.exp_fwd) begin
      check({tag, " ready_k3"}, 64'(req_ready), 64'd1);
    end else begin
      check({tag, " ready_hold1"}, 64'(req_ready), 64'd0);
      tick();
      check({tag, " ready_hold2"}, 64'(req_ready), 64'd0);
      tick();
      check({tag, " ready_k5"}, 64'(req_ready), 64'd1);
    end
  endtask

  vec_t bp;

  initial begin
`ifdef HEAP_MAX_ORDER_EN
    add(5'd1,  32'd5,  32'd7,  32'd9,  32'd9,  1'b1, 5'd3);
    add(5'd2,  32'd20, 32'd8,  32'd3,  32'd20, 1'b0, 5'd0);
    add(5'd3,  32'd20, 32'd6,  32'd6,  32'd20, 1'b0, 5'd0);
    add(5'd5,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd0);
    add(5'd6,  32'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd12);
    add(5'd17, 32'd100, 32'd50, 32'd40, 32'd100, 1'b0, 5'd0);
    add(5'd4,  32'd7,  32'd7,  32'd9,  32'd9,  1'b1, 5'd9);
    add(5'd1,  32'd5,  32'h8000_0000, 32'd9, 32'h8000_0000, 1'b1, 5'd2);
    add(5'd2,  32'd4,  32'd9,  32'd2,  32'd9,  1'b1, 5'd4);
    add(5'd7,  32'd0,  32'd0,  32'd0,  32'd0,  1'b0, 5'd0);
`else
    add(5'd1,  32'd5,  32'd7,  32'd9,  32'd5,  1'b0, 5'd0);
    add(5'd2,  32'd20, 32'd8,  32'd3,  32'd3,  1'b1, 5'd5);
    add(5'd3,  32'd20, 32'd6,  32'd6,  32'd6,  1'b1, 5'd6);
    add(5'd5,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd0);
    add(5'd6,  32'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd10, 1'b0, 5'd0);
    add(5'd17, 32'd100, 32'd50, 32'd40, 32'd40, 1'b1, 5'd3);
    add(5'd4,  32'd7,  32'd7,  32'd9,  32'd7,  1'b0, 5'd0);
    add(5'd1,  32'd5,  32'h8000_0000, 32'd9, 32'd5, 1'b0, 5'd0);
    add(5'd2,  32'd4,  32'd9,  32'd2,  32'd2,  1'b1, 5'd5);
`endif

    tick(); tick();
    check("rst req_ready", 64'(req_ready), 64'd1);
    check("rst par_we", 64'(par_we), 64'd0);
    check("rst fwd_valid", 64'(fwd_valid), 64'd0);
    check("rst ch_addr", 64'(ch_addr), 64'd0);
    check("rst par_addr", 64'(par_addr), 64'd0);
    check("rst par_branch", 64'(par_branch), 64'd0);
    check("rst par_din", 64'(par_din), 64'd0);
    check("rst fwd_idx", 64'(fwd_idx), 64'd0);
    check("rst fwd_data", 64'(fwd_data), 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-pressure: fwd_ready low for 4 cycles after WR.
    bp.p = 5'd2; bp.v = 32'd4; bp.l = 32'd9; bp.r = 32'd2;
`ifdef HEAP_MAX_ORDER_EN
    bp.exp_din = 32'd9; bp.exp_fidx = 5'd4;
`else
    bp.exp_din = 32'd2; bp.exp_fidx = 5'd5;
`endif
    bp.exp_fwd = 1'b1;
    fwd_ready = 1'b0;
    start_req(bp, "bp");
    for (int c = 0; c < 4; c++) begin
      tick();
      check("bp fwd_valid_held", 64'(fwd_valid), 64'd1);
      check("bp fwd_idx_stable", 64'(fwd_idx), 64'(bp.exp_fidx));
      check("bp fwd_data_stable", 64'(fwd_data), 64'(bp.v));
      check("bp ready_low", 64'(req_ready), 64'd0);
      check("bp we_low", 64'(par_we), 64'd0);
    end
    fwd_ready = 1'b1;
    tick();
    check("bp fwd_dropped", 64'(fwd_valid), 64'd0);
    check("bp hold1_ready", 64'(req_ready), 64'd0);
    tick();
    check("bp hold2_ready", 64'(req_ready), 64'd0);
    tick();
    check("bp idle_ready", 64'(req_ready), 64'd1);

    // Reset during CMP.
    req_valid = 1'b1; req_idx = bp.p; req_data = bp.v;
    ch_l_dout = bp.l; ch_r_dout = bp.r;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("rcmp par_we", 64'(par_we), 64'd0);
    check("rcmp fwd_valid", 64'(fwd_valid), 64'd0);
    check("rcmp req_ready", 64'(req_ready), 64'd1);
    rst = 1'b0;
    tick();
    run_vec(bp, "after_rcmp");

    // Reset during FWD.
    fwd_ready = 1'b0;
    start_req(bp, "rfwd");
    tick();
    check("rfwd in_fwd", 64'(fwd_valid), 64'd1);
    rst = 1'b1;
    tick();
    check("rfwd par_we", 64'(par_we), 64'd0);
    check("rfwd fwd_valid", 64'(fwd_valid), 64'd0);
    check("rfwd req_ready", 64'(req_ready), 64'd1);
    check("rfwd fwd_idx", 64'(fwd_idx), 64'd0);
    rst = 1'b0;
    tick();
    run_vec(vecs[0], "after_rfwd");

    // Leaf node: write one cycle after accept, never forwards.
    check("leaf ready", 64'(l_req_ready), 64'd1);
    l_req_valid = 1'b1; l_req_idx = 5'd5; l_req_data = 32'd33;
    l_ch_l_dout = 32'd0; l_ch_r_dout = 32'd0;
    tick();
    l_req_valid = 1'b0;
    check("leaf we", 64'(l_par_we), 64'd1);
    check("leaf din", 64'(l_par_din), 64'd33);
    check("leaf addr", 64'(l_par_addr), 64'd2);
    check("leaf branch", 64'(l_par_branch), 64'd1);
    check("leaf fwd", 64'(l_fwd_valid), 64'd0);
    check("leaf ready_low", 64'(l_req_ready), 64'd0);
    tick();
    check("leaf we_off", 64'(l_par_we), 64'd0);
    check("leaf fwd2", 64'(l_fwd_valid), 64'd0);
    check("leaf ready_back", 64'(l_req_ready), 64'd1);
    check("leaf ch_addr", 64'(l_ch_addr), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
